mem_ctrl: RTL and testbench

Memory controller between the core's byte-wide RAM/IO port and its two clients: the instruction cache (word fetches) and the load/store buffer (byte/half/word loads and stores). It serialises every access into consecutive byte cycles and reassembles read data little-endian. It arbitrates the two clients and returns a one-cycle ready pulse per completed transaction. It is the direct upstream feeder of the instruction cache.

---
 rtl/mem_ctrl_pkg.sv | 47 ++++
 rtl/mem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for mem_ctrl: size codes, FSM states, IO base,
// and the latched LSB request payload.
package mem_ctrl_pkg;

  localparam int unsigned MC_ADDR_WIDTH = 32;
  localparam int unsigned MC_DATA_WIDTH = 32;
  localparam int unsigned MC_IO_BASE    = 32'h0003_0000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mc_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFETCH,
    ST_LOAD,
    ST_STORE,
    ST_DONE
  } mc_state_e;

  // Transaction payload latched at grant time (address kept separately, it is parameterised)
  typedef struct packed {
    logic [2:0]               len;
    logic [MC_DATA_WIDTH-1:0] data;
  } mc_req_t;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] data_byte(input logic [MC_DATA_WIDTH-1:0] data,
                                           input logic [1:0] idx);
    case (idx)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      2'd2:    return data[23:16];
      default: return data[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating icache fetches and LSB loads/stores.
// Optional MC_ROUND_ROBIN_EN: alternate IDLE arbitration priority between the clients.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = MC_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(MC_IO_BASE)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rollback_in,
  input  logic                     ic_to_mc_request,
  input  logic [ADDR_WIDTH-1:0]    ic_to_mc_pc,
  output logic                     mc_to_ic_rdy,
  output logic [MC_DATA_WIDTH-1:0] mc_to_ic_inst,
  input  logic                     lsb_to_mc_request,
  input  logic                     lsb_to_mc_wr,
  input  logic [1:0]               lsb_to_mc_size,
  input  logic [ADDR_WIDTH-1:0]    lsb_to_mc_addr,
  input  logic [MC_DATA_WIDTH-1:0] lsb_to_mc_data,
  output logic                     mc_to_lsb_rdy,
  output logic [MC_DATA_WIDTH-1:0] mc_to_lsb_data,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_WIDTH-1:0]    mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  mc_state_e                state_q, state_d;
  mc_req_t                  req_q, req_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [23:0]              buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]    mem_a_q, mem_a_d;
  logic [7:0]               mem_dout_q, mem_dout_d;
  logic                     mem_wr_q, mem_wr_d;
  logic                     ic_rdy_q, ic_rdy_d;
  logic [MC_DATA_WIDTH-1:0] ic_inst_q, ic_inst_d;
  logic                     lsb_rdy_q, lsb_rdy_d;
  logic [MC_DATA_WIDTH-1:0] lsb_data_q, lsb_data_d;

  logic                     grant_lsb;
  logic                     grant_ic;
  logic [ADDR_WIDTH-1:0]    st_addr;

`ifdef MC_ROUND_ROBIN_EN
  logic last_lsb_q, last_lsb_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_lsb_q <= 1'b0;
    end else if (rdy_in) begin
      last_lsb_q <= last_lsb_d;
    end
  end

  // On a tie the client not granted last time wins
  always_comb begin
    last_lsb_d = last_lsb_q;
    grant_lsb  = lsb_to_mc_request && (!ic_to_mc_request || !last_lsb_q);
    grant_ic   = ic_to_mc_request && !grant_lsb;
    if (state_q == ST_IDLE && !rollback_in) begin
      if (grant_lsb) begin
        last_lsb_d = 1'b1;
      end else if (grant_ic) begin
        last_lsb_d = 1'b0;
      end
    end
  end
`else
  always_comb begin
    grant_lsb = lsb_to_mc_request;
    grant_ic  = ic_to_mc_request && !lsb_to_mc_request;
  end
`endif

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_rdy_q   <= 1'b0;
      ic_inst_q  <= '0;
      lsb_rdy_q  <= 1'b0;
      lsb_data_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_rdy_q   <= ic_rdy_d;
      ic_inst_q  <= ic_inst_d;
      lsb_rdy_q  <= lsb_rdy_d;
      lsb_data_q <= lsb_data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    ic_rdy_d   = 1'b0;
    ic_inst_d  = ic_inst_q;
    lsb_rdy_d  = 1'b0;
    lsb_data_d = lsb_data_q;
    st_addr    = addr_q + ADDR_WIDTH'(cnt_q);

    case (state_q)
      ST_IDLE: begin
        mem_a_d = '0;
        if (!rollback_in) begin
          if (grant_lsb) begin
            addr_d     = lsb_to_mc_addr;
            req_d.len  = size_to_len(lsb_to_mc_size);
            req_d.data = lsb_to_mc_data;
            buf_d      = '0;
            mem_a_d    = lsb_to_mc_addr;
            cnt_d      = 3'd0;
            if (lsb_to_mc_wr) begin
              state_d = ST_STORE;
              // First store byte is issued straight from the request ports
              if (!(lsb_to_mc_addr >= IO_BASE && io_buffer_full)) begin
                mem_wr_d   = 1'b1;
                mem_dout_d = lsb_to_mc_data[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = ST_LOAD;
            end
          end else if (grant_ic) begin
            addr_d    = ic_to_mc_pc;
            req_d.len = 3'd4;
            buf_d     = '0;
            mem_a_d   = ic_to_mc_pc;
            cnt_d     = 3'd0;
            state_d   = ST_IFETCH;
          end
        end
      end

      ST_IFETCH, ST_LOAD: begin
        if (rollback_in) begin
          state_d = ST_IDLE;
          mem_a_d = '0;
        end else if (cnt_q == req_q.len) begin
          // Last byte is on mem_din now: merge it directly into the result
          state_d = ST_DONE;
          mem_a_d = '0;
          if (state_q == ST_IFETCH) begin
            ic_inst_d = {mem_din, buf_q};
            ic_rdy_d  = 1'b1;
          end else begin
            case (req_q.len)
              3'd1:    lsb_data_d = {24'h0, mem_din};
              3'd2:    lsb_data_d = {16'h0, mem_din, buf_q[7:0]};
              default: lsb_data_d = {mem_din, buf_q};
            endcase
            lsb_rdy_d = 1'b1;
          end
        end else begin
          case (cnt_q)
            3'd1:    buf_d[7:0]   = mem_din;
            3'd2:    buf_d[15:8]  = mem_din;
            3'd3:    buf_d[23:16] = mem_din;
            default: ;
          endcase
          if (3'(cnt_q + 3'd1) < req_q.len) begin
            mem_a_d = addr_q + ADDR_WIDTH'(3'(cnt_q + 3'd1));
          end
          cnt_d = 3'(cnt_q + 3'd1);
        end
      end

      ST_STORE: begin
        if (cnt_q == req_q.len) begin
          state_d   = ST_DONE;
          mem_a_d   = '0;
          lsb_rdy_d = 1'b1;
        end else begin
          mem_a_d = st_addr;
          // A full IO buffer holds the byte index; the same byte is retried
          if (!(st_addr >= IO_BASE && io_buffer_full)) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = data_byte(req_q.data, cnt_q[1:0]);
            cnt_d      = 3'(cnt_q + 3'd1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        mem_a_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        mem_a_d = '0;
      end
    endcase
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = mem_wr_q;
  assign mc_to_ic_rdy   = ic_rdy_q;
  assign mc_to_ic_inst  = ic_inst_q;
  assign mc_to_lsb_rdy  = lsb_rdy_q;
  assign mc_to_lsb_data = lsb_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a registered-read byte RAM model.
// Cycle 0 is the cycle a request is first driven; cycle k follows the k-th edge after it.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rollback_in;
  logic        ic_to_mc_request;
  logic [31:0] ic_to_mc_pc;
  logic        mc_to_ic_rdy;
  logic [31:0] mc_to_ic_inst;
  logic        lsb_to_mc_request;
  logic        lsb_to_mc_wr;
  logic [1:0]  lsb_to_mc_size;
  logic [31:0] lsb_to_mc_addr;
  logic [31:0] lsb_to_mc_data;
  logic        mc_to_lsb_rdy;
  logic [31:0] mc_to_lsb_data;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [logic [31:0]];

  mem_ctrl dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rollback_in       (rollback_in),
    .ic_to_mc_request  (ic_to_mc_request),
    .ic_to_mc_pc       (ic_to_mc_pc),
    .mc_to_ic_rdy      (mc_to_ic_rdy),
    .mc_to_ic_inst     (mc_to_ic_inst),
    .lsb_to_mc_request (lsb_to_mc_request),
    .lsb_to_mc_wr      (lsb_to_mc_wr),
    .lsb_to_mc_size    (lsb_to_mc_size),
    .lsb_to_mc_addr    (lsb_to_mc_addr),
    .lsb_to_mc_data    (lsb_to_mc_data),
    .mc_to_lsb_rdy     (mc_to_lsb_rdy),
    .mc_to_lsb_data    (mc_to_lsb_data),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // RAM shares the global enable so a frozen core sees a frozen read port
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram_rd(mem_a);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem: a=%h wr=%b dout=%h, expected 0/0/0", mem_a, mem_wr, mem_dout);
    end
    checks++;
    if (mc_to_ic_rdy !== 1'b0 || mc_to_lsb_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: ic=%b lsb=%b, expected 0/0", mc_to_ic_rdy, mc_to_lsb_rdy);
    end
    checks++;
    if (mc_to_ic_inst !== 32'h0 || mc_to_lsb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: inst=%h data=%h, expected 0/0", mc_to_ic_inst, mc_to_lsb_data);
    end
    tick();
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_ifetch();
    ic_to_mc_request = 1'b1;
    ic_to_mc_pc      = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 4) begin
        checks++;
        if (mem_a !== 32'(c - 1) || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL ifetch_addr c%0d: a=%h wr=%b, expected a=%h wr=0", c, mem_a, mem_wr, c - 1);
        end
      end
      checks++;
      if (mc_to_ic_rdy !== 1'(c == 6)) begin
        errors++;
        $display("FAIL ifetch_rdy c%0d: rdy=%b, expected %b", c, mc_to_ic_rdy, c == 6);
      end
      if (c == 6) begin
        checks++;
        if (mc_to_ic_inst !== 32'h0000_0013) begin
          errors++;
          $display("FAIL ifetch_inst: got %h, expected 00000013", mc_to_ic_inst);
        end
        ic_to_mc_request = 1'b0;
      end
    end
    checks++;
    if (mem_a !== 32'h0) begin
      errors++;
      $display("FAIL ifetch_no_refetch: a=%h, expected 0", mem_a);
    end
  endtask

  task automatic test_first_tie();
    bit lsb_seen = 0;
    bit ic_seen  = 0;
    ic_to_mc_request  = 1'b1;
    ic_to_mc_pc       = 32'h0;
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b10;
    lsb_to_mc_addr    = 32'h100;
    for (int c = 1; c <= 20 && !ic_seen; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_a !== 32'h100) begin
          errors++;
          $display("FAIL tie1_grant: a=%h, expected 00000100 (LSB first)", mem_a);
        end
      end
      if (mc_to_lsb_rdy === 1'b1) begin
        lsb_seen = 1;
        checks++;
        if (c != 6 || mc_to_lsb_data !== 32'hCDAB_0201) begin
          errors++;
          $display("FAIL tie1_lsb: cycle %0d data %h, expected cycle 6 data cdab0201", c, mc_to_lsb_data);
        end
        lsb_to_mc_request = 1'b0;
      end
      if (mc_to_ic_rdy === 1'b1) begin
        ic_seen = 1;
        checks++;
        if (c != 13 || mc_to_ic_inst !== 32'h13 || !lsb_seen) begin
          errors++;
          $display("FAIL tie1_ic: cycle %0d inst %h lsb_before=%b, expected cycle 13 inst 00000013 lsb_before=1",
                   c, mc_to_ic_inst, lsb_seen);
        end
        ic_to_mc_request = 1'b0;
      end
    end
    checks++;
    if (!ic_seen || !lsb_seen) begin
      errors++;
      $display("FAIL tie1_timeout: ic_seen=%b lsb_seen=%b, expected 1/1", ic_seen, lsb_seen);
    end
    ic_to_mc_request  = 1'b0;
    lsb_to_mc_request = 1'b0;
    tick();
  endtask

  task automatic test_byte_load();
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b00;
    lsb_to_mc_addr    = 32'h103;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_a !== 32'h103) begin
          errors++;
          $display("FAIL byte_addr: a=%h, expected 00000103", mem_a);
        end
      end
      checks++;
      if (mc_to_lsb_rdy !== 1'(c == 3)) begin
        errors++;
        $display("FAIL byte_rdy c%0d: rdy=%b, expected %b", c, mc_to_lsb_rdy, c == 3);
      end
      if (c == 3) begin
        checks++;
        if (mc_to_lsb_data !== 32'h0000_00CD) begin
          errors++;
          $display("FAIL byte_data: got %h, expected 000000cd", mc_to_lsb_data);
        end
        lsb_to_mc_request = 1'b0;
      end
    end
  endtask

  task automatic test_second_tie();
    int exp_a, exp_ic_c, exp_lsb_c;
    int ic_c  = 0;
    int lsb_c = 0;
`ifdef MC_ROUND_ROBIN_EN
    exp_a = 32'h0;   exp_ic_c = 6;  exp_lsb_c = 10;
`else
    exp_a = 32'h102; exp_ic_c = 10; exp_lsb_c = 3;
`endif
    ic_to_mc_request  = 1'b1;
    ic_to_mc_pc       = 32'h0;
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b00;
    lsb_to_mc_addr    = 32'h102;
    for (int c = 1; c <= 20 && (ic_c == 0 || lsb_c == 0); c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_a !== 32'(exp_a)) begin
          errors++;
          $display("FAIL tie2_grant: a=%h, expected %h", mem_a, exp_a);
        end
      end
      if (mc_to_ic_rdy === 1'b1) begin
        ic_c = c;
        ic_to_mc_request = 1'b0;
      end
      if (mc_to_lsb_rdy === 1'b1) begin
        lsb_c = c;
        checks++;
        if (mc_to_lsb_data !== 32'h0000_00AB) begin
          errors++;
          $display("FAIL tie2_data: got %h, expected 000000ab", mc_to_lsb_data);
        end
        lsb_to_mc_request = 1'b0;
      end
    end
    checks++;
    if (ic_c != exp_ic_c || lsb_c != exp_lsb_c) begin
      errors++;
      $display("FAIL tie2_order: ic rdy cycle %0d lsb rdy cycle %0d, expected %0d/%0d", ic_c, lsb_c, exp_ic_c, exp_lsb_c);
    end
    ic_to_mc_request  = 1'b0;
    lsb_to_mc_request = 1'b0;
    tick();
  endtask

  task automatic test_half_load();
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b01;
    lsb_to_mc_addr    = 32'h102;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        checks++;
        if (mem_a !== 32'(32'h102 + c - 1)) begin
          errors++;
          $display("FAIL half_addr c%0d: a=%h, expected %h", c, mem_a, 32'h102 + c - 1);
        end
      end
      checks++;
      if (mc_to_lsb_rdy !== 1'(c == 4)) begin
        errors++;
        $display("FAIL half_rdy c%0d: rdy=%b, expected %b", c, mc_to_lsb_rdy, c == 4);
      end
      if (c == 4) begin
        checks++;
        if (mc_to_lsb_data !== 32'h0000_CDAB) begin
          errors++;
          $display("FAIL half_data: got %h, expected 0000cdab", mc_to_lsb_data);
        end
        lsb_to_mc_request = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_io_store();
    logic [5:0]  exp_wr   = 6'b111001;  // bit k-1 = mem_wr in cycle k
    logic [31:0] exp_word = 32'h1122_3344;
    logic [31:0] got_word;
    int k = 0;
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b1;
    lsb_to_mc_size    = 2'b10;
    lsb_to_mc_addr    = 32'h3_0000;
    lsb_to_mc_data    = exp_word;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 6) begin
        checks++;
        if (mem_wr !== exp_wr[c-1]) begin
          errors++;
          $display("FAIL io_wr c%0d: wr=%b, expected %b", c, mem_wr, exp_wr[c-1]);
        end
        if (exp_wr[c-1]) begin
          checks++;
          if (mem_a !== 32'(32'h3_0000 + k) || mem_dout !== exp_word[8*k +: 8]) begin
            errors++;
            $display("FAIL io_byte c%0d: a=%h dout=%h, expected a=%h dout=%h",
                     c, mem_a, mem_dout, 32'h3_0000 + k, exp_word[8*k +: 8]);
          end
          k++;
        end
      end
      checks++;
      if (mc_to_lsb_rdy !== 1'(c == 7)) begin
        errors++;
        $display("FAIL io_rdy c%0d: rdy=%b, expected %b", c, mc_to_lsb_rdy, c == 7);
      end
      // Buffer reported full at the edges opening cycles 2 and 3
      if (c == 1) io_buffer_full = 1'b1;
      if (c == 3) io_buffer_full = 1'b0;
      if (c == 7) lsb_to_mc_request = 1'b0;
    end
    got_word = {ram_rd(32'h3_0003), ram_rd(32'h3_0002), ram_rd(32'h3_0001), ram_rd(32'h3_0000)};
    checks++;
    if (got_word !== exp_word) begin
      errors++;
      $display("FAIL io_ram: got %h, expected %h", got_word, exp_word);
    end
    tick();
  endtask

  task automatic test_rollback_ifetch();
    int rdy_hits = 0;
    ic_to_mc_request = 1'b1;
    ic_to_mc_pc      = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (mc_to_ic_rdy === 1'b1) rdy_hits++;
      if (c == 3) begin
        rollback_in      = 1'b1;
        ic_to_mc_request = 1'b0;
      end
      if (c == 4) begin
        checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL rb_ifetch_idle: a=%h wr=%b, expected 0/0", mem_a, mem_wr);
        end
        rollback_in = 1'b0;
      end
    end
    checks++;
    if (rdy_hits != 0) begin
      errors++;
      $display("FAIL rb_ifetch_rdy: %0d rdy pulses, expected 0", rdy_hits);
    end
  endtask

  task automatic test_rollback_store();
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b1;
    lsb_to_mc_size    = 2'b01;
    lsb_to_mc_addr    = 32'h200;
    lsb_to_mc_data    = 32'h0000_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) rollback_in = 1'b1;
      if (c == 3) begin
        checks++;
        if (mc_to_lsb_rdy !== 1'b1) begin
          errors++;
          $display("FAIL rb_store_rdy: rdy=%b, expected 1", mc_to_lsb_rdy);
        end
        rollback_in       = 1'b0;
        lsb_to_mc_request = 1'b0;
      end
    end
    checks++;
    if (ram_rd(32'h200) !== 8'hEF || ram_rd(32'h201) !== 8'hBE) begin
      errors++;
      $display("FAIL rb_store_ram: got %h %h, expected ef be", ram_rd(32'h200), ram_rd(32'h201));
    end
    tick();
  endtask

  task automatic test_rdy_in_stall();
    int rdy_c = 0;
    lsb_to_mc_request = 1'b1;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b10;
    lsb_to_mc_addr    = 32'h100;
    for (int c = 1; c <= 14 && rdy_c == 0; c++) begin
      tick();
      if (c == 2) rdy_in = 1'b0;
      if (c == 4) begin
        checks++;
        if (mem_a !== 32'h101) begin
          errors++;
          $display("FAIL freeze_addr: a=%h, expected 00000101", mem_a);
        end
      end
      if (c == 5) rdy_in = 1'b1;
      if (mc_to_lsb_rdy === 1'b1) begin
        rdy_c = c;
        checks++;
        if (mc_to_lsb_data !== 32'hCDAB_0201) begin
          errors++;
          $display("FAIL freeze_data: got %h, expected cdab0201", mc_to_lsb_data);
        end
        lsb_to_mc_request = 1'b0;
      end
    end
    checks++;
    if (rdy_c != 9) begin
      errors++;
      $display("FAIL freeze_rdy_cycle: rdy in cycle %0d, expected 9", rdy_c);
    end
    rdy_in            = 1'b1;
    lsb_to_mc_request = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ic_to_mc_request = 1'b1;
    ic_to_mc_pc      = 32'h0;
    tick();
    tick();
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mc_to_ic_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mem: a=%h wr=%b rdy=%b, expected 0/0/0", mem_a, mem_wr, mc_to_ic_rdy);
    end
    checks++;
    if (mc_to_ic_inst !== 32'h0 || mc_to_lsb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_data: inst=%h data=%h, expected 0/0", mc_to_ic_inst, mc_to_lsb_data);
    end
    ic_to_mc_request = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  initial begin
    rst_in            = 1'b1;
    rdy_in            = 1'b1;
    rollback_in       = 1'b0;
    ic_to_mc_request  = 1'b0;
    ic_to_mc_pc       = '0;
    lsb_to_mc_request = 1'b0;
    lsb_to_mc_wr      = 1'b0;
    lsb_to_mc_size    = 2'b00;
    lsb_to_mc_addr    = '0;
    lsb_to_mc_data    = '0;
    io_buffer_full    = 1'b0;
    ram[32'h0]   = 8'h13;
    ram[32'h1]   = 8'h00;
    ram[32'h2]   = 8'h00;
    ram[32'h3]   = 8'h00;
    ram[32'h100] = 8'h01;
    ram[32'h101] = 8'h02;
    ram[32'h102] = 8'hAB;
    ram[32'h103] = 8'hCD;
    #1;
    rst_in = 1'b0;

    test_reset();
    test_ifetch();
    test_first_tie();
    test_byte_load();
    test_second_tie();
    test_half_load();
    test_io_store();
    test_rollback_ifetch();
    test_rollback_store();
    test_rdy_in_stall();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
